muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer with architectural HI/LO registers for the MIPS150 pipeline.
- Executes MULT, MULTU, DIV and DIVU over WIDTH+2 busy cycles.
- Exports busy so the hazard logic can stall MFHI/MFLO until the result is ready.
- Serves MTHI/MTLO writes and exposes HI/LO to the writeback mux.

---
 rtl/muldiv_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer with architectural HI/LO.
//
// Runs MULT, MULTU, DIV and DIVU over WIDTH+2 busy cycles:
//   PREP: operands reduced to magnitudes and result signs recorded,
//   RUN : WIDTH shift-add (mul) or restoring shift-subtract (div) steps,
//   FIX : sign correction and writeback to HI/LO.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start, op      launch request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU),
//                  sampled only in IDLE
//   rs_val, rt_val multiplicand/dividend and multiplier/divisor, sampled with start
//   flush          synchronous abort of any operation in flight
//   mthi, mtlo     load wdata into HI / LO (IDLE only, start and flush take priority)
//   busy           high whenever an operation is in flight
//   done           one-cycle pulse when HI/LO take a new result
//   div_by_zero    one-cycle pulse with done for a divide by zero
//   hi, lo         architectural HI and LO registers
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched request
  logic [1:0]       op_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;

  // Iteration datapath
  logic [WIDTH-1:0] mag_b;   // multiplicand or divisor magnitude
  logic [2*WIDTH:0] acc;     // {partial/remainder (WIDTH+1), multiplier/quotient (WIDTH)}
  logic [CW-1:0]    cnt;
  logic             neg_q;   // product / quotient is negative
  logic             neg_r;   // remainder is negative (follows dividend)

  // Control strobes
  logic launch;
  logic mt_ok;
  logic commit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && !flush) state_next = PREP;
      PREP: state_next = flush ? IDLE : RUN;
      RUN: begin
        if (flush)             state_next = IDLE;
        else if (cnt == LAST)  state_next = FIX;
      end
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state != IDLE);
    launch = (state == IDLE) && start && !flush;
    mt_ok  = (state == IDLE) && !start && !flush;
    commit = (state == FIX) && !flush;
  end

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  logic             is_div;
  logic             is_signed;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_step;
  logic [2*WIDTH:0] div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_zero;

  always_comb begin
    is_div    = op_q[1];
    is_signed = !op_q[0];
    rs_mag    = (is_signed && rs_q[WIDTH-1]) ? -rs_q : rs_q;
    rt_mag    = (is_signed && rt_q[WIDTH-1]) ? -rt_q : rt_q;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole register right.
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    mul_step = {1'b0, mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the dividend bit into the remainder, subtract
    // the divisor if it fits and record a quotient bit in the vacated LSB.
    // The remainder is always below the divisor, so acc[2*WIDTH] is zero here.
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_ok    = div_shift[2*WIDTH:WIDTH] >= {1'b0, mag_b};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, mag_b};
    div_step  = div_ok ? {div_diff, div_shift[WIDTH-1:1], 1'b1} : div_shift;

    prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    div_zero = (rt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;

      if (launch) begin
        op_q <= op;
        rs_q <= rs_val;
        rt_q <= rt_val;
      end

      if (state == PREP) begin
        mag_b <= is_div ? rt_mag : rs_mag;
        acc   <= {{(WIDTH+1){1'b0}}, (is_div ? rs_mag : rt_mag)};
        neg_q <= is_signed && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
        neg_r <= is_signed && rs_q[WIDTH-1];
        cnt   <= '0;
      end

      if (state == RUN) begin
        acc <= is_div ? div_step : mul_step;
        cnt <= cnt + CW'(1);
      end

      // Most-negative / -1 needs no special case: the magnitude quotient
      // 2^(WIDTH-1) negates back onto itself and the remainder is zero.
      if (commit) begin
        done <= 1'b1;
        if (is_div) begin
          if (div_zero) begin
            lo          <= '1;
            hi          <= rs_q;
            div_by_zero <= 1'b1;
          end else begin
            lo <= quot_fix;
            hi <= rem_fix;
          end
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else if (mt_ok) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl (WIDTH=32): directed cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  rs_val = '0;
  logic [W-1:0]  rt_val = '0;
  logic          flush = 1'b0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics straight from 64-bit integer arithmetic.
  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl, output logic z);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    z  = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'b01: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; rl = '1; rh = a;
        end else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  // inject: 0 none, 1 mthi+mtlo while busy, 2 second start while busy,
  //         3 mthi+mtlo in the same cycle as start
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
    logic [W-1:0] eh, el;
    logic ez;
    int cyc, busy_cnt, extra_done;
    ref_op(o, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (inject == 3) begin mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    cyc = 1; busy_cnt = 0;
    if (inject == 3) begin
      check("start_wins_hi", hi, m_hi);
      check("start_wins_lo", lo, m_lo);
    end
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (inject == 1 && cyc == 5) begin mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; end
      if (inject == 1 && cyc == 6) begin
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_busy_hi", hi, m_hi);
        check("mt_busy_lo", lo, m_lo);
      end
      if (inject == 2 && cyc == 10) begin
        start = 1'b1; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
      if (inject == 2 && cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(W + 3));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 2));
    check("busy_at_done", 64'(busy), 64'(0));
    check("hi", hi, eh);
    check("lo", lo, el);
    check("dbz", 64'(div_by_zero), 64'(ez));
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("dbz_pulse", 64'(div_by_zero), 64'(0));
    if (inject == 2) begin
      extra_done = 0;
      for (int k = 0; k < 40; k++) begin
        if (done) extra_done++;
        @(negedge clk);
      end
      check("ignored_start_busy", 64'(busy), 64'(0));
      check("ignored_start_done", 64'(extra_done), 64'(0));
    end
  endtask

  // Abort an operation with flush at busy cycle 'at' (1 = PREP, 34 = FIX).
  task automatic flush_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int at);
    int nd;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < at; k++) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(nd), 64'(0));
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    mthi = h; mtlo = l; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_dbz", 64'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);

    // HI/LO moves
    mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
    mt_write(1'b0, 1'b1, 32'h5A5A_5A5A);
    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 1);
    run_op(2'b11, 32'd1000, 32'd33, 3);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0010, 2);

    // Flush at PREP, mid-RUN and FIX
    flush_op(2'b01, 32'd123, 32'd456, 1);
    flush_op(2'b10, 32'hFFFF_0000, 32'd3, 5);
    flush_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, W + 2);

    // Flush in IDLE suppresses start and moves
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b01; rs_val = 3; rt_val = 4; wdata = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("idle_flush_busy", 64'(busy), 0);
    check("idle_flush_hi", hi, m_hi);
    check("idle_flush_lo", lo, m_lo);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("idle_flush_no_done", 64'(nd), 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, 0);
    end

    // Reset mid-RUN
    mt_write(1'b1, 1'b1, 32'h1111_2222);
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_done", 64'(done), 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, 0);
    check("after_rst_lo", lo, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
